// File: rtl/cpu_pkg.sv
// Shared widths and FSM encoding for the instruction cache.
// Also used by the data cache, which reuses icache_word_sel.
package cpu_pkg;

    localparam int ADDR_W      = 10;
    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_BYTES = 16;

    localparam int INDEX_W  = $clog2(NUM_BLOCKS);
    localparam int OFFSET_W = $clog2(BLOCK_BYTES);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORD_W   = OFFSET_W - 2;
    localparam int BLOCK_W  = BLOCK_BYTES * 8;
    localparam int BADDR_W  = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } icache_state_t;

endpackage

// File: rtl/icache_word_sel.sv
// Combinational selection of one 32-bit word from a 128-bit line.
// Word 0 is the lowest-addressed word (bits [31:0]).
module icache_word_sel
    import cpu_pkg::*;
(
    input  logic [BLOCK_W-1:0] line,
    input  logic [WORD_W-1:0]  word,
    output logic [31:0]        data
);

    // pick the addressed word out of the line
    always_comb begin
        data = line[32*word +: 32];
    end

endmodule

// File: rtl/ins_cache.sv
// Direct-mapped read-only instruction cache, 8 lines of 16 bytes.
// Optional ICACHE_STATS_EN adds saturating hit/miss counters.
module ins_cache
    import cpu_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               read,
    input  logic [ADDR_W-1:0]  address,
    output logic [31:0]        instruction,
    output logic               busywait,
    output logic               mem_read,
    output logic [BADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);

    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [WORD_W-1:0]  word;

    assign tag   = address[ADDR_W-1 -: TAG_W];
    assign index = address[OFFSET_W +: INDEX_W];
    assign word  = address[2 +: WORD_W];

    // byte lane within a word is irrelevant for fetch
    logic unused_bits;
    assign unused_bits = ^address[1:0];

    logic [NUM_BLOCKS-1:0] valid;
    logic [TAG_W-1:0]      tags [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data [NUM_BLOCKS];

    icache_state_t state;
    icache_state_t state_d;

    logic               first;
    logic [BADDR_W-1:0] miss_addr;
    logic [TAG_W-1:0]   miss_tag;
    logic [INDEX_W-1:0] miss_idx;

    assign miss_tag = miss_addr[BADDR_W-1 -: TAG_W];
    assign miss_idx = miss_addr[INDEX_W-1:0];

    logic hit;
    logic latch;
    logic fill;

    assign hit = read & valid[index] & (tags[index] == tag);

    logic [31:0] sel_word;

    icache_word_sel u_word_sel (
        .line (data[index]),
        .word (word),
        .data (sel_word)
    );

    // only a hit drives a real instruction onto the fetch bus
    always_comb begin
        instruction = hit ? sel_word : 32'h0;
    end

    // next state, stall and line-fill controls
    always_comb begin
        state_d  = state;
        busywait = 1'b0;
        latch    = 1'b0;
        fill     = 1'b0;
        unique case (state)
            IDLE: begin
                busywait = read & ~hit;
                if (read & ~hit) begin
                    latch   = 1'b1;
                    state_d = MEM_READ;
                end
            end
            MEM_READ: begin
                busywait = 1'b1;
                // memory raises busywait one cycle after read
                if (!first && !mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busywait = 1'b1;
                fill     = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state register and registered memory request
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            first       <= 1'b0;
            miss_addr   <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
        end else begin
            state    <= state_d;
            first    <= latch;
            mem_read <= (state_d == MEM_READ);
            if (latch) begin
                miss_addr   <= {tag, index};
                mem_address <= {tag, index};
            end
        end
    end

    // valid bits; a reset mid-miss leaves the line invalid
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
        end else if (fill) begin
            valid[miss_idx] <= 1'b1;
        end
    end

    // line data and tag storage, no reset needed
    always_ff @(posedge clock) begin
        if (fill && !reset) begin
            data[miss_idx] <= mem_readdata;
            tags[miss_idx] <= miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    // saturating hit and miss counters
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && hit && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (latch && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ins_cache.sv
// Self-checking bench for ins_cache with a behavioural block memory.
// Expected instructions are queued on drive and popped on completion.
module tb_ins_cache;

    logic         clock;
    logic         reset;
    logic         read;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    int passed = 0;
    int total  = 0;
    int mrd_cycles = 0;
    logic [31:0] exp_q[$];

    ins_cache dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // reference instruction content at a byte address
    function automatic logic [31:0] model_word(input logic [9:0] a);
        logic [7:0] w;
        w = a[9:2];
        return {w ^ 8'h5A, w, ~w, 8'hFA};
    endfunction

    function automatic logic [127:0] model_line(input logic [5:0] b);
        logic [127:0] l;
        for (int j = 0; j < 4; j++) begin
            l[32*j +: 32] = model_word({b, j[1:0], 2'b00});
        end
        return l;
    endfunction

    // block memory: busy for LAT cycles after read is seen
    localparam int LAT = 4;
    logic mbusy;
    logic mdone;
    int   mcnt;
    assign mem_busywait = mbusy;

    always @(posedge clock) begin
        if (!mem_read) begin
            mbusy <= 1'b0;
            mdone <= 1'b0;
            mcnt  <= 0;
        end else if (!mbusy && !mdone) begin
            mbusy <= 1'b1;
            mcnt  <= LAT;
        end else if (mbusy) begin
            if (mcnt == 1) begin
                mbusy        <= 1'b0;
                mdone        <= 1'b1;
                mem_readdata <= model_line(mem_address);
            end
            mcnt <= mcnt - 1;
        end
        if (mem_read) mrd_cycles <= mrd_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h want %h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        read  = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busywait && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_tmo"}, 32'(n < 40), 32'd1);
    endtask

    // fetch one address; a hit consumes one clock, a miss waits it out
    task automatic fetch(input logic [9:0] a, input bit miss);
        logic [31:0] e;
        read    = 1'b1;
        address = a;
        exp_q.push_back(model_word(a));
        #1;
        check("busy", 32'(busywait), 32'(miss));
        if (miss) begin
            @(negedge clock);
            check("mrd", 32'(mem_read), 32'd1);
            check("madr", 32'(mem_address), 32'(a[9:4]));
        end
        wait_idle("fetch");
        e = exp_q.pop_front();
        check("ins", instruction, e);
        if (!miss) @(negedge clock);
    endtask

    int m0;

    initial begin
        reset        = 1'b0;
        read         = 1'b0;
        address      = '0;
        mbusy        = 1'b0;
        mdone        = 1'b0;
        mcnt         = 0;
        mem_readdata = '0;

        do_reset();
        #1;
        check("rst_busy", 32'(busywait), 32'd0);
        check("rst_mrd", 32'(mem_read), 32'd0);
        check("rst_madr", 32'(mem_address), 32'd0);
        check("rst_ins", instruction, 32'd0);

        // cold miss then three hits in the same line
        fetch(10'h000, 1'b1);
        m0 = mrd_cycles;
        fetch(10'h004, 1'b0);
        fetch(10'h008, 1'b0);
        fetch(10'h00C, 1'b0);
        check("hit_nomrd", 32'(mrd_cycles), 32'(m0));
`ifdef ICACHE_STATS_EN
        check("st_miss", 32'(miss_count), 32'd1);
        check("st_hit", 32'(hit_count), 32'd3);
`endif

        // idle fetch bus
        read = 1'b0;
        #1;
        check("rd0_busy", 32'(busywait), 32'd0);
        check("rd0_ins", instruction, 32'd0);
        @(negedge clock);

        // conflict on index 1
        fetch(10'h010, 1'b1);
        fetch(10'h090, 1'b1);
        fetch(10'h010, 1'b1);
        fetch(10'h000, 1'b0);

        // reset while the refill is in flight
        read    = 1'b1;
        address = 10'h020;
        @(negedge clock);
        check("mm_mrd", 32'(mem_read), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mm_mrd0", 32'(mem_read), 32'd0);
        check("mm_madr", 32'(mem_address), 32'd0);
        check("mm_busy", 32'(busywait), 32'd1);
`ifdef ICACHE_STATS_EN
        check("st_rmiss", 32'(miss_count), 32'd0);
        check("st_rhit", 32'(hit_count), 32'd0);
`endif
        reset = 1'b0;
        fetch(10'h020, 1'b1);

        // address moves while stalled
        begin
            int n;
            logic [31:0] e;
            read    = 1'b1;
            address = 10'h030;
            #1;
            check("st_busy", 32'(busywait), 32'd1);
            @(negedge clock);
            check("st_madr0", 32'(mem_address), 32'h03);
            address = 10'h040;
            exp_q.push_back(model_word(10'h040));
            n = 0;
            while (mem_read && n < 40) begin
                check("st_madr", 32'(mem_address), 32'h03);
                @(negedge clock);
                n++;
            end
            check("st_tmo", 32'(n < 40), 32'd1);
            check("st_upd", 32'(busywait), 32'd1);
            @(negedge clock);
            check("st_remiss", 32'(busywait), 32'd1);
            @(negedge clock);
            check("st_mrd2", 32'(mem_read), 32'd1);
            check("st_madr2", 32'(mem_address), 32'h04);
            wait_idle("st");
            e = exp_q.pop_front();
            check("st_ins", instruction, e);
        end
        fetch(10'h030, 1'b0);

        // top of the address space
        fetch(10'h3FC, 1'b1);
        fetch(10'h3F0, 1'b0);
        fetch(10'h3F7, 1'b0);

        read = 1'b0;
        check("q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
